mem_axi_arbiter: RTL

MEM_AXI_ARBITER -- requirements
Module: mem_axi_arbiter

---
 rtl/mem_axi_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_axi_arbiter.sv
// ----------------------------------------------------------------------------
// mem_axi_arbiter
//
// Two-master to one-slave AXI4 arbiter in front of the PS DDR port.
//   * AR and AW are arbitrated independently. Each channel has a two-state
//     IDLE/GRANT FSM with a round-robin pointer. A grant costs one cycle, so
//     each channel completes at most one handshake every two cycles.
//   * Every AW handshake pushes the granted master index into a small
//     write-order queue. The W channel follows the queue head and pops it
//     when the beat with last=1 is accepted.
//   * R and B are routed back combinationally by id bit 5.
//   * Slave address is {ADDR_BASE, addr[27:0]}. Slave id is
//     {master_index, id[4:0]}.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   m{0,1}_ar_* / m{0,1}_aw_*    master read/write address channels (in)
//   m{0,1}_w_*                   master write data channels (in)
//   m{0,1}_r_* / m{0,1}_b_*      master read data / write response (out)
//   s_ar_*, s_aw_*, s_w_*        slave request channels (out)
//   s_r_*, s_b_*                 slave response channels (in)
// ----------------------------------------------------------------------------
module mem_axi_arbiter #(
    parameter logic [3:0] ADDR_BASE = 4'd1,
    parameter int         WQ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_ar_valid,
    output logic        m0_ar_ready,
    input  logic [31:0] m0_ar_addr,
    input  logic [4:0]  m0_ar_id,
    input  logic [7:0]  m0_ar_len,
    input  logic [2:0]  m0_ar_size,
    input  logic [1:0]  m0_ar_burst,
    input  logic        m1_ar_valid,
    output logic        m1_ar_ready,
    input  logic [31:0] m1_ar_addr,
    input  logic [4:0]  m1_ar_id,
    input  logic [7:0]  m1_ar_len,
    input  logic [2:0]  m1_ar_size,
    input  logic [1:0]  m1_ar_burst,

    input  logic        m0_aw_valid,
    output logic        m0_aw_ready,
    input  logic [31:0] m0_aw_addr,
    input  logic [4:0]  m0_aw_id,
    input  logic [7:0]  m0_aw_len,
    input  logic [2:0]  m0_aw_size,
    input  logic [1:0]  m0_aw_burst,
    input  logic        m1_aw_valid,
    output logic        m1_aw_ready,
    input  logic [31:0] m1_aw_addr,
    input  logic [4:0]  m1_aw_id,
    input  logic [7:0]  m1_aw_len,
    input  logic [2:0]  m1_aw_size,
    input  logic [1:0]  m1_aw_burst,

    input  logic        m0_w_valid,
    output logic        m0_w_ready,
    input  logic [63:0] m0_w_data,
    input  logic [7:0]  m0_w_strb,
    input  logic        m0_w_last,
    input  logic        m1_w_valid,
    output logic        m1_w_ready,
    input  logic [63:0] m1_w_data,
    input  logic [7:0]  m1_w_strb,
    input  logic        m1_w_last,

    output logic        m0_r_valid,
    input  logic        m0_r_ready,
    output logic [4:0]  m0_r_id,
    output logic [63:0] m0_r_data,
    output logic [1:0]  m0_r_resp,
    output logic        m0_r_last,
    output logic        m1_r_valid,
    input  logic        m1_r_ready,
    output logic [4:0]  m1_r_id,
    output logic [63:0] m1_r_data,
    output logic [1:0]  m1_r_resp,
    output logic        m1_r_last,

    output logic        m0_b_valid,
    input  logic        m0_b_ready,
    output logic [4:0]  m0_b_id,
    output logic [1:0]  m0_b_resp,
    output logic        m1_b_valid,
    input  logic        m1_b_ready,
    output logic [4:0]  m1_b_id,
    output logic [1:0]  m1_b_resp,

    output logic        s_ar_valid,
    input  logic        s_ar_ready,
    output logic [31:0] s_ar_addr,
    output logic [5:0]  s_ar_id,
    output logic [7:0]  s_ar_len,
    output logic [2:0]  s_ar_size,
    output logic [1:0]  s_ar_burst,

    output logic        s_aw_valid,
    input  logic        s_aw_ready,
    output logic [31:0] s_aw_addr,
    output logic [5:0]  s_aw_id,
    output logic [7:0]  s_aw_len,
    output logic [2:0]  s_aw_size,
    output logic [1:0]  s_aw_burst,

    output logic        s_w_valid,
    input  logic        s_w_ready,
    output logic [63:0] s_w_data,
    output logic [7:0]  s_w_strb,
    output logic        s_w_last,

    input  logic        s_r_valid,
    output logic        s_r_ready,
    input  logic [5:0]  s_r_id,
    input  logic [63:0] s_r_data,
    input  logic [1:0]  s_r_resp,
    input  logic        s_r_last,

    input  logic        s_b_valid,
    output logic        s_b_ready,
    input  logic [5:0]  s_b_id,
    input  logic [1:0]  s_b_resp
);

    localparam int PTR_W = (WQ_DEPTH > 2) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(WQ_DEPTH + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} ch_state_e;

    // Round-robin pick. With both masters requesting, ptr names the winner.
    // With one request, that master wins regardless of ptr.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) return ptr;
        return v1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ch_state_e            ar_state_q, ar_state_d;
    logic                 ar_gnt_q,   ar_gnt_d;
    logic                 ar_ptr_q,   ar_ptr_d;
    ch_state_e            aw_state_q, aw_state_d;
    logic                 aw_gnt_q,   aw_gnt_d;
    logic                 aw_ptr_q,   aw_ptr_d;

    logic [WQ_DEPTH-1:0]  wq_mem_q,   wq_mem_d;
    logic [PTR_W-1:0]     wq_wr_q,    wq_wr_d;
    logic [PTR_W-1:0]     wq_rd_q,    wq_rd_d;
    logic [CNT_W-1:0]     wq_cnt_q,   wq_cnt_d;

    logic ar_hs, aw_hs, w_hs;
    logic wq_empty, wq_room, wq_head;
    logic wq_push, wq_pop;

    // ------------------------------------------------------------------
    // AR channel
    // ------------------------------------------------------------------
    assign s_ar_valid  = (ar_state_q == ST_GRANT) && (ar_gnt_q ? m1_ar_valid : m0_ar_valid);
    assign m0_ar_ready = (ar_state_q == ST_GRANT) && !ar_gnt_q && s_ar_ready;
    assign m1_ar_ready = (ar_state_q == ST_GRANT) &&  ar_gnt_q && s_ar_ready;
    assign ar_hs       = s_ar_valid && s_ar_ready;

    assign s_ar_addr  = {ADDR_BASE, ar_gnt_q ? m1_ar_addr[27:0] : m0_ar_addr[27:0]};
    assign s_ar_id    = {ar_gnt_q, ar_gnt_q ? m1_ar_id : m0_ar_id};
    assign s_ar_len   = ar_gnt_q ? m1_ar_len   : m0_ar_len;
    assign s_ar_size  = ar_gnt_q ? m1_ar_size  : m0_ar_size;
    assign s_ar_burst = ar_gnt_q ? m1_ar_burst : m0_ar_burst;

    // NOTE: every variable gets a default at the top of a combinational
    // block. Without it, a path that skips an assignment infers a latch.
    always_comb begin
        ar_state_d = ar_state_q;
        ar_gnt_d   = ar_gnt_q;
        ar_ptr_d   = ar_ptr_q;
        case (ar_state_q)
            ST_IDLE: begin
                if (m0_ar_valid || m1_ar_valid) begin
                    ar_gnt_d   = rr_pick(m0_ar_valid, m1_ar_valid, ar_ptr_q);
                    ar_state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ar_hs) begin
                    ar_state_d = ST_IDLE;
                    ar_ptr_d   = !ar_gnt_q;
                end
            end
            default: ar_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // AW channel. A grant also needs room in the write-order queue.
    // ------------------------------------------------------------------
    assign s_aw_valid  = (aw_state_q == ST_GRANT) && (aw_gnt_q ? m1_aw_valid : m0_aw_valid);
    assign m0_aw_ready = (aw_state_q == ST_GRANT) && !aw_gnt_q && s_aw_ready;
    assign m1_aw_ready = (aw_state_q == ST_GRANT) &&  aw_gnt_q && s_aw_ready;
    assign aw_hs       = s_aw_valid && s_aw_ready;

    assign s_aw_addr  = {ADDR_BASE, aw_gnt_q ? m1_aw_addr[27:0] : m0_aw_addr[27:0]};
    assign s_aw_id    = {aw_gnt_q, aw_gnt_q ? m1_aw_id : m0_aw_id};
    assign s_aw_len   = aw_gnt_q ? m1_aw_len   : m0_aw_len;
    assign s_aw_size  = aw_gnt_q ? m1_aw_size  : m0_aw_size;
    assign s_aw_burst = aw_gnt_q ? m1_aw_burst : m0_aw_burst;

    always_comb begin
        aw_state_d = aw_state_q;
        aw_gnt_d   = aw_gnt_q;
        aw_ptr_d   = aw_ptr_q;
        case (aw_state_q)
            ST_IDLE: begin
                if ((m0_aw_valid || m1_aw_valid) && wq_room) begin
                    aw_gnt_d   = rr_pick(m0_aw_valid, m1_aw_valid, aw_ptr_q);
                    aw_state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (aw_hs) begin
                    aw_state_d = ST_IDLE;
                    aw_ptr_d   = !aw_gnt_q;
                end
            end
            default: aw_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-order queue and W steering
    // ------------------------------------------------------------------
    assign wq_empty = (wq_cnt_q == '0);
    assign wq_room  = (wq_cnt_q < CNT_W'(WQ_DEPTH));
    assign wq_head  = wq_mem_q[wq_rd_q];

    assign s_w_valid  = !wq_empty && (wq_head ? m1_w_valid : m0_w_valid);
    assign m0_w_ready = !wq_empty && !wq_head && s_w_ready;
    assign m1_w_ready = !wq_empty &&  wq_head && s_w_ready;
    assign s_w_data   = wq_head ? m1_w_data : m0_w_data;
    assign s_w_strb   = wq_head ? m1_w_strb : m0_w_strb;
    assign s_w_last   = wq_head ? m1_w_last : m0_w_last;
    assign w_hs       = s_w_valid && s_w_ready;

    assign wq_push = aw_hs;
    assign wq_pop  = w_hs && s_w_last;

    always_comb begin
        wq_mem_d = wq_mem_q;
        wq_wr_d  = wq_wr_q;
        wq_rd_d  = wq_rd_q;
        wq_cnt_d = wq_cnt_q;
        if (wq_push) begin
            wq_mem_d[wq_wr_q] = aw_gnt_q;
            wq_wr_d           = wq_wr_q + 1'b1;
        end
        if (wq_pop) begin
            wq_rd_d = wq_rd_q + 1'b1;
        end
        case ({wq_push, wq_pop})
            2'b10:   wq_cnt_d = wq_cnt_q + 1'b1;
            2'b01:   wq_cnt_d = wq_cnt_q - 1'b1;
            default: wq_cnt_d = wq_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // R / B return routing (purely combinational)
    // ------------------------------------------------------------------
    assign m0_r_valid = s_r_valid && !s_r_id[5];
    assign m1_r_valid = s_r_valid &&  s_r_id[5];
    assign m0_r_id    = s_r_id[4:0];
    assign m1_r_id    = s_r_id[4:0];
    assign m0_r_data  = s_r_data;
    assign m1_r_data  = s_r_data;
    assign m0_r_resp  = s_r_resp;
    assign m1_r_resp  = s_r_resp;
    assign m0_r_last  = s_r_last;
    assign m1_r_last  = s_r_last;
    assign s_r_ready  = s_r_id[5] ? m1_r_ready : m0_r_ready;

    assign m0_b_valid = s_b_valid && !s_b_id[5];
    assign m1_b_valid = s_b_valid &&  s_b_id[5];
    assign m0_b_id    = s_b_id[4:0];
    assign m1_b_id    = s_b_id[4:0];
    assign m0_b_resp  = s_b_resp;
    assign m1_b_resp  = s_b_resp;
    assign s_b_ready  = s_b_id[5] ? m1_b_ready : m0_b_ready;

    // The upper address nibble is replaced by ADDR_BASE.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_ar_addr[31:28], m1_ar_addr[31:28],
                                m0_aw_addr[31:28], m1_aw_addr[31:28]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q <= ST_IDLE;
            ar_gnt_q   <= 1'b0;
            ar_ptr_q   <= 1'b0;
            aw_state_q <= ST_IDLE;
            aw_gnt_q   <= 1'b0;
            aw_ptr_q   <= 1'b0;
            wq_wr_q    <= '0;
            wq_rd_q    <= '0;
            wq_cnt_q   <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            ar_gnt_q   <= ar_gnt_d;
            ar_ptr_q   <= ar_ptr_d;
            aw_state_q <= aw_state_d;
            aw_gnt_q   <= aw_gnt_d;
            aw_ptr_q   <= aw_ptr_d;
            wq_wr_q    <= wq_wr_d;
            wq_rd_q    <= wq_rd_d;
            wq_cnt_q   <= wq_cnt_d;
        end
    end

    // NOTE: queue storage is not reset. An entry is only read while the
    // count says it is valid, so clearing the count and pointers is enough.
    always_ff @(posedge clk) begin
        wq_mem_q <= wq_mem_d;
    end

endmodule
